// File: rtl/sevenseg_scan_driver.sv
// Four-digit common-anode 7-segment scanner with per-scan snapshot and anti-ghost blanking.
// Define SEVENSEG_ALARM_BLINK_EN to blink the display while the snapshot reads 0000 and running=1.
module sevenseg_scan_driver #(
  parameter int unsigned DIGIT_PERIOD = 100000,
  parameter int unsigned BLANK_CYCLES = 2000,
  parameter int unsigned BLINK_HALF   = 250
) (
  input  logic       clk100MHz,
  input  logic       rst_n,
  input  logic [3:0] tenmin,
  input  logic [3:0] onemin,
  input  logic [3:0] tensec,
  input  logic [3:0] onesec,
  input  logic       colon_en,
  input  logic       running,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned DivW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;

  logic [DivW-1:0] r_div;
  logic [1:0]      r_digit;
  logic [15:0]     r_snap;        // {tenmin, onemin, tensec, onesec}
  logic            r_snap_colon;

  logic       w_wrap;
  logic       w_blank_slot;
  logic       w_hide;
  logic [3:0] w_nibble;
  logic [6:0] w_seg;

  assign w_wrap       = (r_div == DivW'(DIGIT_PERIOD - 1));
  assign w_blank_slot = (r_div < DivW'(BLANK_CYCLES));
  assign w_nibble     = r_snap[{r_digit, 2'b00} +: 4];

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_div        <= '0;
      r_digit      <= 2'd0;
      r_snap       <= 16'h0000;
      r_snap_colon <= 1'b0;
    end else if (w_wrap) begin
      r_div   <= '0;
      r_digit <= r_digit + 2'd1;
      // Load on the 3->0 wrap so the next scan shows one coherent value.
      if (r_digit == 2'd3) begin
        r_snap       <= {tenmin, onemin, tensec, onesec};
        r_snap_colon <= colon_en;
      end
    end else begin
      r_div <= r_div + DivW'(1);
    end
  end

  always_comb begin
    w_seg = 7'h3F;
    case (w_nibble)
      4'd0:    w_seg = 7'h40;
      4'd1:    w_seg = 7'h79;
      4'd2:    w_seg = 7'h24;
      4'd3:    w_seg = 7'h30;
      4'd4:    w_seg = 7'h19;
      4'd5:    w_seg = 7'h12;
      4'd6:    w_seg = 7'h02;
      4'd7:    w_seg = 7'h78;
      4'd8:    w_seg = 7'h00;
      4'd9:    w_seg = 7'h10;
      default: w_seg = 7'h3F;
    endcase
  end

`ifdef SEVENSEG_ALARM_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BlinkW-1:0] r_blink_cnt;
  logic              r_phase;
  logic              w_alarm;

  assign w_alarm = (r_snap == 16'h0000) && running;
  // Gate with the live alarm so dropping running un-hides on the very next output cycle.
  assign w_hide  = w_alarm && r_phase;

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (!w_alarm) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_wrap) begin
      if (r_blink_cnt == BlinkW'(BLINK_HALF - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BlinkW'(1);
      end
    end
  end
`else
  logic w_unused_running;

  assign w_unused_running = running;
  assign w_hide           = 1'b0;
`endif

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= (w_blank_slot || w_hide) ? 4'b1111 : ~(4'b0001 << r_digit);
      seg <= w_seg;
      dp  <= ~((r_digit == 2'd2) && r_snap_colon && !w_blank_slot && !w_hide);
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver: directed steps plus random inputs,
// compared every cycle against a time-indexed reference model.
module tb_sevenseg_scan_driver;

  localparam int unsigned DP = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned BH = 3;
`ifdef SEVENSEG_ALARM_BLINK_EN
  localparam bit BlinkOn = 1'b1;
`else
  localparam bit BlinkOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] tenmin, onemin, tensec, onesec;
  logic       colon_en, running;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .DIGIT_PERIOD(DP),
    .BLANK_CYCLES(BC),
    .BLINK_HALF  (BH)
  ) dut (
    .clk100MHz(clk),
    .rst_n    (rst_n),
    .tenmin   (tenmin),
    .onemin   (onemin),
    .tensec   (tensec),
    .onesec   (onesec),
    .colon_en (colon_en),
    .running  (running),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: t = cycles since reset release, snapshot per full scan,
  // nwr = digit-period wraps seen while the alarm condition has held.
  int         t;
  int         nwr;
  logic [3:0] m_snap [4];
  logic       m_colon;
  logic [6:0] seg_tab [16];

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    nwr     = 0;
    m_colon = 1'b0;
    for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
  endtask

  task automatic cyc();
    int         pos, dig;
    logic       alarm, hide;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    pos   = t % DP;
    dig   = (t / DP) % 4;
    alarm = BlinkOn && running &&
            (m_snap[0] == 0) && (m_snap[1] == 0) && (m_snap[2] == 0) && (m_snap[3] == 0);
    hide  = alarm && (((nwr / BH) % 2) == 1);
    e_an  = (pos < BC || hide) ? 4'b1111 : ~(4'b0001 << dig);
    e_seg = seg_tab[m_snap[dig]];
    e_dp  = !(dig == 2 && m_colon && pos >= BC && !hide);
    if (!alarm) nwr = 0;
    else if (pos == DP - 1) nwr++;
    if (t % (4 * DP) == 4 * DP - 1) begin
      m_snap[0] = onesec;
      m_snap[1] = tensec;
      m_snap[2] = onemin;
      m_snap[3] = tenmin;
      m_colon   = colon_en;
    end
    t++;
    @(posedge clk);
    #1;
    chk("an", {3'b000, an}, {3'b000, e_an});
    chk("seg", seg, e_seg);
    chk("dp", {6'd0, dp}, {6'd0, e_dp});
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"}, {3'b000, an}, 7'h0F);
    chk({tag, "_seg"}, seg, 7'h7F);
    chk({tag, "_dp"}, {6'd0, dp}, 7'h01);
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    tenmin = a;
    onemin = b;
    tensec = c;
    onesec = d;
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    model_reset();
    rst_n    = 1'b0;
    colon_en = 1'b0;
    running  = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);

    // Reset held across clock edges.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst_hold");
    rst_n = 1'b1;
    model_reset();
    run(45);

    // Asynchronous reset mid-scan, checked between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_async_clk");
    rst_n = 1'b1;
    model_reset();
    run(40);

    // Scan a steady 12:59.
    set_digits(4'd1, 4'd2, 4'd5, 4'd9);
    run(80);

    // Change mid-scan while digit 1 is active.
    while (((t / DP) % 4) != 1) cyc();
    run(3);
    set_digits(4'd1, 4'd3, 4'd0, 4'd0);
    run(70);

    // Colon plus an out-of-range digit.
    colon_en = 1'b1;
    onemin   = 4'hC;
    run(70);

    // Expired timer: blinks when the feature is built in, steady scan otherwise.
    colon_en = 1'b1;
    running  = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    run(230);
    running = 1'b0;
    run(40);
    running = 1'b1;
    run(120);
    colon_en = 1'b0;
    run(40);

    // Random inputs held for random durations.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3, 0) == 0) set_digits(4'd0, 4'd0, 4'd0, 4'd0);
      else set_digits(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                      4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
      colon_en = 1'($urandom_range(1, 0));
      running  = 1'($urandom_range(1, 0));
      run(int'($urandom_range(60, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
